// File: rtl/lbp_hist.sv
// lbp_hist: accumulates a histogram of 8-bit LBP codes for one image, then streams the bins out.
// Latency: a code counted on edge N is visible on edge N+1; bin 0 is offered the cycle after finish.
// Backpressure: each bin holds on hist_bin/hist_count until hist_ready; the next bin follows with no gap.
//
// Optional feature macro: LBP_HIST_UNIFORM_EN. When defined, the block uses 59 bins with uniform
// mapping: the 58 codes with at most 2 circular 0/1 transitions each get their own bin, in
// ascending code order, and every other code goes to bin 58. When undefined, it uses 256 bins
// and a code is its own bin.
//
// Ports:
//   clk, reset (async, active low)
//   lbp_valid/lbp_addr/lbp_data  - one LBP code per valid cycle (address is not stored)
//   finish                       - end of image from the LBP stage; starts the bin dump
//   hist_valid/hist_bin/hist_count, hist_ready - bin stream to the sink
//   pix_cnt                      - number of codes accepted (saturating)
//   hist_done                    - high once the last bin has been accepted, until reset
module lbp_hist #(
   parameter int CNT_W = 15,
   parameter int N_PIX = 16384
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lbp_valid,
   input  logic [13:0]      lbp_addr,
   input  logic [7:0]       lbp_data,
   input  logic             finish,
   input  logic             hist_ready,
   output logic             hist_valid,
   output logic [7:0]       hist_bin,
   output logic [CNT_W-1:0] hist_count,
   output logic [14:0]      pix_cnt,
   output logic             hist_done
);

`ifdef LBP_HIST_UNIFORM_EN
   localparam int NB = 59;
`else
   localparam int NB = 256;
`endif
   localparam int BIN_W = $clog2(NB);
   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NB - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      DUMP  = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [BIN_W-1:0] idx_q, idx_d;
   logic [14:0]      pix_q, pix_d;
   logic [CNT_W-1:0] bin_q [NB];
   logic [CNT_W-1:0] bin_d [NB];
   logic [BIN_W-1:0] code_bin;

   // The address only tags a pixel for the upstream stage; the image size is tracked by pix_cnt.
   logic cfg_unused;
   assign cfg_unused = (^lbp_addr) ^ (N_PIX != 0);

`ifdef LBP_HIST_UNIFORM_EN
   function automatic int circ_transitions(input int c);
      int t;
      t = 0;
      for (int i = 0; i < 8; i++) begin
         if (((c >> i) & 1) != ((c >> ((i + 1) % 8)) & 1)) t++;
      end
      return t;
   endfunction

   // Rank of a uniform code among all uniform codes; non-uniform codes share the last bin.
   function automatic int uniform_bin(input int c);
      int r;
      r = 0;
      if (circ_transitions(c) > 2) return 58;
      for (int k = 0; k < c; k++) begin
         if (circ_transitions(k) <= 2) r++;
      end
      return r;
   endfunction

   // Built from constants at elaboration, so this is a fixed 256-entry lookup.
   logic [BIN_W-1:0] map_lut [256];
   for (genvar g = 0; g < 256; g++) begin : g_map
      assign map_lut[g] = BIN_W'(uniform_bin(g));
   end
   assign code_bin = map_lut[lbp_data];
`else
   assign code_bin = lbp_data;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pix_d   = pix_q;
      bin_d   = bin_q;
      case (state_q)
         ACCUM: begin
            // A code arriving on the finish edge still belongs to this image.
            if (lbp_valid) begin
               if (bin_q[code_bin] != CNT_MAX) bin_d[code_bin] = bin_q[code_bin] + 1'b1;
               if (pix_q != 15'h7fff) pix_d = pix_q + 1'b1;
            end
            if (finish) state_d = DUMP;
         end
         DUMP: begin
            if (hist_ready) begin
               if (idx_q == LAST_BIN) state_d = DONE;
               else                   idx_d   = idx_q + 1'b1;
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ACCUM;
         idx_q   <= '0;
         pix_q   <= '0;
         for (int i = 0; i < NB; i++) bin_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pix_q   <= pix_d;
         for (int i = 0; i < NB; i++) bin_q[i] <= bin_d[i];
      end
   end

   // Outputs decode straight from registered state so reset clears them without a clock.
   always_comb begin
      hist_valid = (state_q == DUMP);
      hist_done  = (state_q == DONE);
      hist_bin   = '0;
      hist_count = '0;
      if (state_q == DUMP) begin
         hist_bin   = 8'(idx_q);
         hist_count = bin_q[idx_q];
      end
      pix_cnt = pix_q;
   end

endmodule

// File: tb/tb_lbp_hist.sv
module tb_lbp_hist;
   localparam int CNT_W = 15;
   localparam int N_PIX = 16384;
`ifdef LBP_HIST_UNIFORM_EN
   localparam int NB    = 59;
   localparam int B5    = 58;   // 0x05 has 4 transitions
   localparam int STOP  = 40;
`else
   localparam int NB    = 256;
   localparam int B5    = 5;
   localparam int STOP  = 100;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             lbp_valid;
   logic [13:0]      lbp_addr;
   logic [7:0]       lbp_data;
   logic             finish;
   logic             hist_ready;
   logic             hist_valid;
   logic [7:0]       hist_bin;
   logic [CNT_W-1:0] hist_count;
   logic [14:0]      pix_cnt;
   logic             hist_done;

   int n_assert = 0;
   int n_fail   = 0;
   int model_bin [NB];
   int obs_bin   [NB];
   int model_pix;
   int uni_codes [$];

   lbp_hist #(.CNT_W(CNT_W), .N_PIX(N_PIX)) dut (
      .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
      .lbp_data(lbp_data), .finish(finish), .hist_ready(hist_ready),
      .hist_valid(hist_valid), .hist_bin(hist_bin), .hist_count(hist_count),
      .pix_cnt(pix_cnt), .hist_done(hist_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference bin mapping straight from the code rules.
   function automatic int ref_map(input int c);
`ifdef LBP_HIST_UNIFORM_EN
      foreach (uni_codes[i]) if (uni_codes[i] == c) return i;
      return 58;
`else
      return c;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < NB; i++) model_bin[i] = 0;
      model_pix = 0;
   endtask

   // One accumulation-phase cycle; the model follows the counting rules.
   task automatic send(input logic v, input logic [7:0] code, input logic fin);
      lbp_valid = v;
      lbp_data  = code;
      lbp_addr  = 14'($urandom);
      finish    = fin;
      if (v) begin
         if (model_bin[ref_map(code)] < (1 << CNT_W) - 1) model_bin[ref_map(code)]++;
         if (model_pix < 32767) model_pix++;
      end
      tick();
      lbp_valid = 1'b0;
      finish    = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      chk({tag, "_valid"}, hist_valid, 0);
      chk({tag, "_bin"},   hist_bin,   0);
      chk({tag, "_count"}, hist_count, 0);
      chk({tag, "_pix"},   pix_cnt,    0);
      chk({tag, "_done"},  hist_done,  0);
      clear_model();
      reset = 1'b1;
      tick();
   endtask

   // Walks the dump; lbp_valid/finish are randomised to show they are ignored here.
   task automatic dump(input int pct, input int hold_bin, input int stop_bin);
      int w;
      chk("dump_done_low", hist_done, 0);
      for (int b = 0; b < NB; b++) begin
         if (b == stop_bin) return;
         w = 0;
         forever begin
            if (b == hold_bin && w < 5) hist_ready = 1'b0;
            else if (b == hold_bin || w >= 20) hist_ready = 1'b1;
            else hist_ready = ($urandom_range(99) < pct);
            lbp_valid = 1'($urandom_range(1));
            lbp_data  = 8'($urandom);
            finish    = 1'($urandom_range(1));
            chk("dump_valid", hist_valid, 1);
            chk("dump_bin",   hist_bin,   b);
            chk("dump_count", hist_count, model_bin[b]);
            obs_bin[b] = int'(hist_count);
            tick();
            if (hist_ready) break;
            w++;
         end
      end
      hist_ready = 1'b0;
      lbp_valid  = 1'b0;
      finish     = 1'b0;
      chk("end_valid", hist_valid, 0);
      chk("end_done",  hist_done,  1);
      chk("end_pix",   pix_cnt,    model_pix);
      repeat (3) begin
         lbp_valid  = 1'b1;
         finish     = 1'b1;
         hist_ready = 1'b1;
         tick();
         chk("done_hold",  hist_done,  1);
         chk("done_valid", hist_valid, 0);
         chk("done_pix",   pix_cnt,    model_pix);
      end
      lbp_valid  = 1'b0;
      finish     = 1'b0;
      hist_ready = 1'b0;
   endtask

   initial begin
      int n;
      for (int c = 0; c < 256; c++) begin
         int rot;
         rot = ((c << 1) | (c >> 7)) & 255;
         if ($countones(c ^ rot) <= 2) uni_codes.push_back(c);
      end
      reset = 1'b0; lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0;
      finish = 1'b0; hist_ready = 1'b0;
      clear_model();

      // Reset state
      #2;
      chk("rst_valid", hist_valid, 0);
      chk("rst_bin",   hist_bin,   0);
      chk("rst_count", hist_count, 0);
      chk("rst_pix",   pix_cnt,    0);
      chk("rst_done",  hist_done,  0);
      tick();
      reset = 1'b1;
      tick();

      // Ten codes 0x05, then dump with the sink always ready
      for (int i = 0; i < 10; i++) send(1'b1, 8'h05, 1'b0);
      chk("r27_pix", pix_cnt, 10);
      send(1'b0, 8'h00, 1'b1);
      dump(100, -1, -1);
      chk("r27_bin5", obs_bin[B5], 10);

      // Random image, last code 0xFF on the finish edge; sink stalls 5 cycles on bin 3
      do_reset("r28_rst");
      n = 0;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(3) == 0) send(1'b0, 8'h00, 1'b0);
         else begin send(1'b1, 8'($urandom), 1'b0); n++; end
      end
      send(1'b1, 8'hFF, 1'b1);
      n++;
      chk("r28_pix", pix_cnt, n);
      dump(70, 3, -1);

      // Full image of zero codes
      do_reset("r29_rst");
      for (int i = 0; i < N_PIX; i++) send(1'b1, 8'h00, 1'b0);
      chk("r29_pix", pix_cnt, N_PIX);
      send(1'b0, 8'h00, 1'b1);
      dump(100, -1, -1);
      chk("r29_bin0", obs_bin[0], N_PIX);

      // Reset in the middle of a dump, then a fresh image
      do_reset("r31_pre");
      for (int i = 0; i < 300; i++) send(1'b1, 8'($urandom), 1'b0);
      send(1'b0, 8'h00, 1'b1);
      dump(60, -1, STOP);
      chk("r31_at_stop", hist_bin, STOP);
      do_reset("r31_mid");
      for (int i = 0; i < 20; i++) send(1'b1, 8'($urandom), 1'b0);
      chk("r31_pix", pix_cnt, 20);
      send(1'b1, 8'($urandom), 1'b1);
      dump(50, -1, -1);

`ifdef LBP_HIST_UNIFORM_EN
      // Uniform mapping: 0x00 -> bin 0, 0x0F -> bin 10, 0x05 -> bin 58
      do_reset("r32_rst");
      send(1'b1, 8'h00, 1'b0);
      send(1'b1, 8'h0F, 1'b0);
      send(1'b1, 8'h05, 1'b1);
      dump(100, -1, -1);
      chk("r32_bin0",  obs_bin[0],  1);
      chk("r32_bin10", obs_bin[10], 1);
      chk("r32_bin58", obs_bin[58], 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
